// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and one-word-per-cycle fetch register with delay-slot, stall and halt handling.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect target raises a sticky addr_fault and halts.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        active,
    output logic        addr_fault
);
    typedef enum logic [1:0] {RUN, HALT_SLOT, HALTED} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pend_target, eff_target;
    logic        pend_valid, eff_redir, advance, misalign;

    assign instr_address = pc;
    assign advance       = state != HALTED && !stall;
    assign eff_redir     = redirect_valid || pend_valid;
    assign eff_target    = redirect_valid ? redirect_target : pend_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign = eff_redir && eff_target[1:0] != 2'b00;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            addr_fault <= 1'b0;
        else if (advance && state == RUN && misalign)
            addr_fault <= 1'b1;
    end
`else
    assign misalign   = 1'b0;
    assign addr_fault = 1'b0;
`endif

    always_comb begin
        state_n = state;
        if (advance)
            state_n = state == HALT_SLOT ? HALTED :
                      misalign ? HALTED :
                      (eff_redir && eff_target == HALT_ADDR) ? HALT_SLOT : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_VECTOR;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            active      <= 1'b1;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            state <= state_n;
            if (advance) begin
                if (state == HALT_SLOT || misalign) begin
                    instr_valid <= 1'b0;
                    active      <= 1'b0;
                    pend_valid  <= 1'b0;
                end else begin
                    instr_out   <= instr_readdata;
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                    pc          <= eff_redir ? eff_target : pc + 32'd4;
                    pend_valid  <= 1'b0;
                end
            end else if (state != HALTED && redirect_valid) begin
                // redirect seen during stall is replayed on the next advance; latest wins
                pend_valid  <= 1'b1;
                pend_target <= redirect_target;
            end
        end
    end
endmodule
